ps2_scan_decoder: RTL and testbench

- Downstream consumer of the PS/2 keyboard byte receiver.
- Pops raw scan-code bytes (set 2), parses E0/F0/E1 prefixes, and tracks modifier and caps-lock state.
- Pushes one packed key event per make/break into a small FWFT FIFO.
- The CPU-side wishbone IO wrapper reads events from the FIFO head instead of raw bytes.

---
 rtl/ps2_pkg.sv | 57 +++++
 rtl/ps2_scan_decoder_if.sv | 22 ++
 rtl/ps2_evt_fifo.sv | 57 +++++
 rtl/ps2_scan_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, event field layout and FSM states for the PS/2 set-2 decoder.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_AA     = 8'hAA;
    localparam logic [7:0] SC_FA     = 8'hFA;
    localparam logic [7:0] SC_FE     = 8'hFE;
    localparam logic [7:0] SC_EE     = 8'hEE;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam int EVT_W         = 24;
    localparam int EVT_ASCII_MSB = 23;
    localparam int EVT_ASCII_LSB = 16;
    localparam int EVT_REL       = 15;
    localparam int EVT_EXT       = 14;
    localparam int EVT_SHIFT     = 13;
    localparam int EVT_CTRL      = 12;
    localparam int EVT_ALT       = 11;
    localparam int EVT_CAPS      = 10;
    localparam int EVT_CODE_MSB  = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    function automatic logic [EVT_W-1:0] packEvent(
        input logic [7:0] ascii,
        input logic       rel,
        input logic       ext,
        input logic       shift,
        input logic       ctrl,
        input logic       alt,
        input logic       caps,
        input logic [7:0] code
    );
        logic [EVT_W-1:0] ev;
        ev = '0;
        ev[EVT_ASCII_MSB:EVT_ASCII_LSB] = ascii;
        ev[EVT_REL]   = rel;
        ev[EVT_EXT]   = ext;
        ev[EVT_SHIFT] = shift;
        ev[EVT_CTRL]  = ctrl;
        ev[EVT_ALT]   = alt;
        ev[EVT_CAPS]  = caps;
        ev[EVT_CODE_MSB:0] = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Event-side bus of the scan decoder: FWFT head, occupancy, sticky flags and their clear.
interface ps2_scan_decoder_if #(
    parameter int AW = 3
);
    logic          evt_valid;
    logic [23:0]   evt_data;
    logic          evt_ack;
    logic [AW:0]   evt_count;
    logic          ovf;
    logic          err;
    logic          flag_clr;

    modport master (
        output evt_valid, evt_data, evt_count, ovf, err,
        input  evt_ack, flag_clr
    );

    modport slave (
        input  evt_valid, evt_data, evt_count, ovf, err,
        output evt_ack, flag_clr
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; a pop frees a slot for a push in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          wrEn, rdEn;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rdEn    = pop_i && !empty_o;
    assign wrEn    = push_i && (!full_o || rdEn);
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_comb begin
        wrPtr_d = wrEn ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = rdEn ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        if (wrEn && !rdEn) begin
            count_d = count_q + 1'b1;
        end else if (!wrEn && rdEn) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code parser: prefix/modifier tracking and packed key events into a FWFT FIFO.
// Define PS2_ASCII_EN to fill evt_data[23:16] with the ASCII of printable keys.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           kbd_data,
    input  logic                 kbd_ready,
    output logic                 kbd_rdn,
    ps2_scan_decoder_if.master   evt
);
    state_e      state_q, state_d;
    logic [7:0]  byte_q;
    logic [2:0]  skipCnt_q, skipCnt_d;
    logic        extPend_q, extPend_d, brkPend_q, brkPend_d;
    logic        lShift_q, lShift_d, rShift_q, rShift_d;
    logic        ctrl_q, ctrl_d, alt_q, alt_d;
    logic        caps_q, caps_d, capsHeld_q, capsHeld_d;
    logic        ovf_q, ovf_d, err_q, err_d;
    logic        latchEn, decodeEn, push, errSet;
    logic [7:0]  asciiByte;
    logic [23:0] evtWord, fifoData;
    logic        fifoFull, fifoEmpty;
    logic [AW:0] fifoCount;

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] asciiOf(input logic [7:0] code, input logic shift,
                                           input logic caps);
        logic [7:0] lo, hi;
        lo = 8'h00;
        hi = 8'h00;
        case (code)
            8'h1C: lo = "a"; 8'h32: lo = "b"; 8'h21: lo = "c"; 8'h23: lo = "d";
            8'h24: lo = "e"; 8'h2B: lo = "f"; 8'h34: lo = "g"; 8'h33: lo = "h";
            8'h43: lo = "i"; 8'h3B: lo = "j"; 8'h42: lo = "k"; 8'h4B: lo = "l";
            8'h3A: lo = "m"; 8'h31: lo = "n"; 8'h44: lo = "o"; 8'h4D: lo = "p";
            8'h15: lo = "q"; 8'h2D: lo = "r"; 8'h1B: lo = "s"; 8'h2C: lo = "t";
            8'h3C: lo = "u"; 8'h2A: lo = "v"; 8'h1D: lo = "w"; 8'h22: lo = "x";
            8'h35: lo = "y"; 8'h1A: lo = "z";
            default: lo = 8'h00;
        endcase
        // Letters follow shift XOR caps; everything else follows shift alone.
        if (lo != 8'h00) begin
            return (shift ^ caps) ? lo - 8'd32 : lo;
        end
        case (code)
            8'h16: begin lo = "1"; hi = "!"; end   8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end   8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end   8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end   8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end   8'h45: begin lo = "0"; hi = ")"; end
            8'h4E: begin lo = "-"; hi = "_"; end   8'h55: begin lo = "="; hi = "+"; end
            8'h54: begin lo = "["; hi = "{"; end   8'h5B: begin lo = "]"; hi = "}"; end
            8'h5D: begin lo = "\\"; hi = "|"; end  8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = "'"; hi = "\""; end  8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end   8'h4A: begin lo = "/"; hi = "?"; end
            8'h0E: begin lo = 8'h60; hi = "~"; end 8'h29: begin lo = " "; hi = " "; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            default: begin lo = 8'h00; hi = 8'h00; end
        endcase
        return shift ? hi : lo;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (kbd_ready) state_d = S_POP;
            S_POP:   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kbd_rdn  = 1'b1;
        decodeEn = 1'b0;
        latchEn  = 1'b0;
        case (state_q)
            S_IDLE:  latchEn = kbd_ready;
            S_POP:   begin kbd_rdn = 1'b0; decodeEn = 1'b1; end
            default: ;
        endcase
    end

    // Modifiers are updated first so the pushed event reflects the key it reports.
    always_comb begin
        skipCnt_d  = skipCnt_q;
        extPend_d  = extPend_q;
        brkPend_d  = brkPend_q;
        lShift_d   = lShift_q;
        rShift_d   = rShift_q;
        ctrl_d     = ctrl_q;
        alt_d      = alt_q;
        caps_d     = caps_q;
        capsHeld_d = capsHeld_q;
        push       = 1'b0;
        errSet     = 1'b0;
        asciiByte  = 8'h00;
        evtWord    = '0;
        if (decodeEn) begin
            if (skipCnt_q != 3'd0) begin
                skipCnt_d = skipCnt_q - 1'b1;
            end else if (byte_q == SC_E1) begin
                skipCnt_d = 3'd7;
                push      = 1'b1;
                evtWord   = packEvent(8'h00, 1'b0, 1'b1, lShift_q | rShift_q, ctrl_q,
                                      alt_q, caps_q, SC_E1);
            end else if (byte_q == SC_E0) begin
                extPend_d = 1'b1;
            end else if (byte_q == SC_F0) begin
                brkPend_d = 1'b1;
            end else if ((byte_q == SC_AA || byte_q == SC_FA || byte_q == SC_FE ||
                          byte_q == SC_EE) && !extPend_q && !brkPend_q) begin
                push = 1'b0;
            end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                errSet    = 1'b1;
                extPend_d = 1'b0;
                brkPend_d = 1'b0;
            end else begin
                extPend_d = 1'b0;
                brkPend_d = 1'b0;
                if (!(extPend_q && byte_q == SC_LSHIFT)) begin
                    if (!extPend_q && byte_q == SC_LSHIFT) lShift_d = !brkPend_q;
                    if (!extPend_q && byte_q == SC_RSHIFT) rShift_d = !brkPend_q;
                    if (byte_q == SC_CTRL) ctrl_d = !brkPend_q;
                    if (byte_q == SC_ALT)  alt_d  = !brkPend_q;
                    if (!extPend_q && byte_q == SC_CAPS) begin
                        if (brkPend_q) begin
                            capsHeld_d = 1'b0;
                        end else if (!capsHeld_q) begin
                            caps_d     = !caps_q;
                            capsHeld_d = 1'b1;
                        end
                    end
`ifdef PS2_ASCII_EN
                    if (!brkPend_q && !extPend_q) begin
                        asciiByte = asciiOf(byte_q, lShift_d | rShift_d, caps_d);
                    end
`else
                    asciiByte = 8'h00;
`endif
                    push    = 1'b1;
                    evtWord = packEvent(asciiByte, brkPend_q, extPend_q, lShift_d | rShift_d,
                                        ctrl_d, alt_d, caps_d, byte_q);
                end
            end
        end
        ovf_d = (push && fifoFull && !evt.evt_ack) || (ovf_q && !evt.flag_clr);
        err_d = errSet || (err_q && !evt.flag_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q     <= 8'h00;
            skipCnt_q  <= 3'd0;
            extPend_q  <= 1'b0;
            brkPend_q  <= 1'b0;
            lShift_q   <= 1'b0;
            rShift_q   <= 1'b0;
            ctrl_q     <= 1'b0;
            alt_q      <= 1'b0;
            caps_q     <= 1'b0;
            capsHeld_q <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (latchEn) byte_q <= kbd_data;
            skipCnt_q  <= skipCnt_d;
            extPend_q  <= extPend_d;
            brkPend_q  <= brkPend_d;
            lShift_q   <= lShift_d;
            rShift_q   <= rShift_d;
            ctrl_q     <= ctrl_d;
            alt_q      <= alt_d;
            caps_q     <= caps_d;
            capsHeld_q <= capsHeld_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    ps2_evt_fifo #(.DEPTH(DEPTH), .AW(AW), .W(EVT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (evtWord),
        .pop_i   (evt.evt_ack),
        .rdata_o (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign evt.evt_valid = !fifoEmpty;
    assign evt.evt_data  = fifoData;
    assign evt.evt_count = fifoCount;
    assign evt.ovf       = ovf_q;
    assign evt.err       = err_q;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: a byte-level receiver plus an event-queue model.
module tb_ps2_scan_decoder;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_rdn;

    ps2_scan_decoder_if #(.AW(AW)) evtIf ();

    ps2_scan_decoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .kbd_rdn   (kbd_rdn),
        .evt       (evtIf.master)
    );

    always #5 clk = ~clk;

    logic [7:0]  rxq[$];
    logic [23:0] mq[$];
    int          mPhase, mSkip;
    bit          mExt, mBrk, mLs, mRs, mCtl, mAlt, mCaps, mHeld, mOvf, mErr;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lit(input logic [7:0] c);
`ifdef PS2_ASCII_EN
        return c;
`else
        return 8'h00 & c;
`endif
    endfunction

    function automatic logic [7:0] mAscii(input logic [7:0] code, input bit shift, input bit caps);
        logic [7:0] c;
        case (code)
            8'h1C: c = "a"; 8'h32: c = "b"; 8'h21: c = "c"; 8'h23: c = "d"; 8'h24: c = "e";
            8'h2B: c = "f"; 8'h34: c = "g"; 8'h33: c = "h"; 8'h43: c = "i"; 8'h4B: c = "l";
            default: c = 8'h00;
        endcase
        if (c != 8'h00 && (shift ^ caps)) c = c - 8'd32;
        return lit(c);
    endfunction

    function automatic logic [23:0] mkEvt(input bit rel, input bit ext, input logic [7:0] code);
        logic [7:0] a;
        a = (rel || ext) ? 8'h00 : mAscii(code, mLs | mRs, mCaps);
        return {a, rel, ext, mLs | mRs, mCtl, mAlt, mCaps, 2'b00, code};
    endfunction

    task automatic mPush(input logic [23:0] ev);
        if (mq.size() < DEPTH) mq.push_back(ev);
        else mOvf = 1;
    endtask

    task automatic modelReset();
        mq.delete();
        mPhase = 0; mSkip = 0;
        mExt = 0; mBrk = 0; mLs = 0; mRs = 0; mCtl = 0; mAlt = 0;
        mCaps = 0; mHeld = 0; mOvf = 0; mErr = 0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        bit rel, ext;
        rel = mBrk;
        ext = mExt;
        if (mSkip > 0) mSkip--;
        else if (b == 8'hE1) begin mSkip = 7; mPush(mkEvt(0, 1, b)); end
        else if (b == 8'hE0) mExt = 1;
        else if (b == 8'hF0) mBrk = 1;
        else if ((b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) && !ext && !rel) mSkip = 0;
        else if (b == 8'h00 || b == 8'hFF) begin mErr = 1; mExt = 0; mBrk = 0; end
        else begin
            mExt = 0;
            mBrk = 0;
            if (!(ext && b == 8'h12)) begin
                if (!ext && b == 8'h12) mLs = !rel;
                if (!ext && b == 8'h59) mRs = !rel;
                if (b == 8'h14) mCtl = !rel;
                if (b == 8'h11) mAlt = !rel;
                if (!ext && b == 8'h58) begin
                    if (rel) mHeld = 0;
                    else if (!mHeld) begin mCaps = !mCaps; mHeld = 1; end
                end
                mPush(mkEvt(rel, ext, b));
            end
        end
    endtask

    task automatic driveKbd();
        kbd_ready = (rxq.size() != 0);
        kbd_data  = kbd_ready ? rxq[0] : 8'h00;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxq.push_back(b);
        driveKbd();
    endtask

    task automatic checkOutput();
        check("kbd_rdn", 32'(kbd_rdn), 32'(mPhase != 1));
        check("evt_valid", 32'(evtIf.evt_valid), 32'(mq.size() != 0));
        check("evt_count", 32'(evtIf.evt_count), 32'(mq.size()));
        if (mq.size() != 0) check("evt_data", 32'(evtIf.evt_data), 32'(mq[0]));
        check("ovf", 32'(evtIf.ovf), 32'(mOvf));
        check("err", 32'(evtIf.err), 32'(mErr));
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit rstNow, ackNow, clrNow;
        logic [7:0] b;
        @(negedge clk);
        checkOutput();
        rstNow = rst;
        ackNow = evtIf.evt_ack;
        clrNow = evtIf.flag_clr;
        @(posedge clk);
        #1;
        if (rstNow) begin
            modelReset();
        end else begin
            if (clrNow) begin mOvf = 0; mErr = 0; end
            if (ackNow && mq.size() > 0) void'(mq.pop_front());
            case (mPhase)
                0: if (rxq.size() > 0) mPhase = 1;
                1: begin b = rxq.pop_front(); modelByte(b); mPhase = 2; end
                default: mPhase = 0;
            endcase
        end
        driveKbd();
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((rxq.size() > 0 || mPhase != 0) && n < 300) begin step(); n++; end
        if (n >= 300) begin
            checks++; errors++;
            $display("[TB] FAIL idle_timeout: got busy expected idle");
        end
        step();
    endtask

    task automatic waitPop();
        int n = 0;
        while (mPhase != 1 && n < 20) begin step(); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL pop_timeout: got phase %0d expected 1", mPhase);
        end
    endtask

    task automatic drainOne(input string name, input logic [23:0] exp);
        check({name, "_valid"}, 32'(evtIf.evt_valid), 32'd1);
        check(name, 32'(evtIf.evt_data), 32'(exp));
        evtIf.evt_ack = 1'b1;
        step();
        evtIf.evt_ack = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        evtIf.evt_ack = 1'b0;
        evtIf.flag_clr = 1'b0;
        rxq.delete();
        driveKbd();
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;
    endtask

    initial begin
        doReset();
        check("rst_kbd_rdn", 32'(kbd_rdn), 32'd1);
        check("rst_evt_valid", 32'(evtIf.evt_valid), 32'd0);
        check("rst_evt_count", 32'(evtIf.evt_count), 32'd0);
        check("rst_ovf", 32'(evtIf.ovf), 32'd0);
        check("rst_err", 32'(evtIf.err), 32'd0);

        applyStimulus(8'h1C);
        step();
        step();
        check("latency_valid", 32'(evtIf.evt_valid), 32'd1);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        waitIdle();
        check("make_break_count", 32'(evtIf.evt_count), 32'd2);
        drainOne("make_1c", {lit(8'h61), 16'h001C});
        drainOne("break_1c", 24'h00801C);

        doReset();
        foreach (rxq[i]) rxq.delete(i);
        begin
            logic [7:0] seq [9] = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C};
            foreach (seq[i]) applyStimulus(seq[i]);
        end
        waitIdle();
        check("mod_count", 32'(evtIf.evt_count), 32'd7);
        drainOne("lshift_make", 24'h002012);
        drainOne("shift_1c", {lit(8'h41), 16'h201C});
        drainOne("lshift_break", 24'h008012);
        drainOne("caps_make", 24'h000458);
        drainOne("caps_repeat", 24'h000458);
        drainOne("caps_break", 24'h008458);
        drainOne("caps_1c", {lit(8'h41), 16'h041C});

        doReset();
        applyStimulus(8'hE0); applyStimulus(8'h75);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        waitIdle();
        drainOne("ext_make", 24'h004075);
        drainOne("ext_break", 24'h00C075);

        doReset();
        begin
            logic [7:0] pause [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
            foreach (pause[i]) applyStimulus(pause[i]);
        end
        waitIdle();
        check("pause_count", 32'(evtIf.evt_count), 32'd2);
        drainOne("pause_evt", 24'h0040E1);
        drainOne("after_pause", {lit(8'h61), 16'h001C});

        doReset();
        begin
            logic [7:0] keys [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
            foreach (keys[i]) applyStimulus(keys[i]);
        end
        waitIdle();
        check("full_count", 32'(evtIf.evt_count), 32'd8);
        check("full_ovf", 32'(evtIf.ovf), 32'd1);
        check("full_head", 32'(evtIf.evt_data), 32'({lit(8'h61), 16'h001C}));
        evtIf.flag_clr = 1'b1;
        step();
        evtIf.flag_clr = 1'b0;
        check("ovf_cleared", 32'(evtIf.ovf), 32'd0);
        applyStimulus(8'h4B);
        waitPop();
        evtIf.evt_ack = 1'b1;
        step();
        evtIf.evt_ack = 1'b0;
        waitIdle();
        check("full_ack_push_count", 32'(evtIf.evt_count), 32'd8);
        check("full_ack_push_head", 32'(evtIf.evt_data), 32'({lit(8'h62), 16'h0032}));
        check("full_ack_push_ovf", 32'(evtIf.ovf), 32'd0);

        doReset();
        applyStimulus(8'hFF);
        waitIdle();
        check("err_set", 32'(evtIf.err), 32'd1);
        check("err_no_event", 32'(evtIf.evt_count), 32'd0);
        evtIf.flag_clr = 1'b1;
        step();
        evtIf.flag_clr = 1'b0;
        check("err_cleared", 32'(evtIf.err), 32'd0);
        applyStimulus(8'h00);
        waitPop();
        evtIf.flag_clr = 1'b1;
        step();
        evtIf.flag_clr = 1'b0;
        check("err_set_wins", 32'(evtIf.err), 32'd1);

        doReset();
        applyStimulus(8'h12);
        waitIdle();
        drainOne("shift_before_rst", 24'h002012);
        applyStimulus(8'h1C);
        waitPop();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rxq.delete();
        driveKbd();
        check("rst_pop_kbd_rdn", 32'(kbd_rdn), 32'd1);
        check("rst_pop_valid", 32'(evtIf.evt_valid), 32'd0);
        applyStimulus(8'h1C);
        waitIdle();
        drainOne("mods_after_rst", {lit(8'h61), 16'h001C});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
